// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding, parity
// mode codes and the data-bit base offset.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned DATA_BITS_BASE = 5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an idle-high asynchronous line; resets to 1 so a
// reset never looks like a start edge.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority vote, false-start rejection
// and parity/framing/break reporting. States: IDLE wait | START verify | DATA | PARITY | STOP.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OS   = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    input  logic [1:0]      i_dbits,
    input  logic [1:0]      i_parity,
    input  logic            i_stop2,
    output logic [DBIT-1:0] o_data,
    output logic            o_rx_done_tick,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_break,
    output logic            o_busy
);

    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_M0   = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_M1   = SW'(OS / 2);
    localparam logic [SW-1:0] S_M2   = SW'(OS / 2 + 1);

    logic rx_s;

    rx_state_t       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [2:0]      samp_q, samp_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [1:0]      cfg_dbits_q, cfg_dbits_d;
    logic [1:0]      cfg_par_q, cfg_par_d;
    logic            cfg_stop2_q, cfg_stop2_d;
    logic            stop_n_q, stop_n_d;
    logic            par_acc_q, par_acc_d;
    logic            perr_acc_q, perr_acc_d;
    logic            ferr_acc_q, ferr_acc_d;
    logic            brk_acc_q, brk_acc_d;
    logic            brk_hold_q, brk_hold_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;
    logic            done_q, done_d;

    logic            vote;
    logic            decision;
    logic            par_en;
    logic            par_odd;
    logic [3:0]      cfg_bits;
    logic [NW-1:0]   nbits;
    logic [NW-1:0]   sh_amt;
    logic            last_data;
    logic            ferr_now;
    logic            brk_now;

    uart_rx_sync u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign decision = i_s_tick && (s_q == S_LAST);
    assign par_en   = (cfg_par_q == PAR_EVEN) || (cfg_par_q == PAR_ODD);
    assign par_odd  = (cfg_par_q == PAR_ODD);
    assign cfg_bits = 4'(DATA_BITS_BASE) + {2'b00, cfg_dbits_q};

    always_comb begin
        if (int'(cfg_bits) > DBIT) nbits = NW'(DBIT);
        else                       nbits = NW'(cfg_bits);
    end

    // Bits enter at the MSB, so a short word is right-justified by this shift.
    assign sh_amt    = NW'(DBIT) - nbits;
    assign last_data = (n_q == nbits - NW'(1));
    assign ferr_now  = ferr_acc_q | ~vote;
    assign brk_now   = stop_n_q ? brk_acc_q : (brk_acc_q & ~vote);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        cfg_dbits_d = cfg_dbits_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;
        stop_n_d    = stop_n_q;
        par_acc_d   = par_acc_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        brk_acc_d   = brk_acc_q;
        brk_hold_d  = brk_hold_q;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        brk_d       = brk_q;
        done_d      = 1'b0;

        if (state_q != IDLE && i_s_tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + SW'(1);
            if (s_q == S_M0) samp_d[0] = rx_s;
            if (s_q == S_M1) samp_d[1] = rx_s;
            if (s_q == S_M2) samp_d[2] = rx_s;
        end

        case (state_q)
            IDLE: begin
                if (rx_s) brk_hold_d = 1'b0;
                if (!rx_s && !brk_hold_q) begin
                    state_d     = START;
                    s_d         = '0;
                    cfg_dbits_d = i_dbits;
                    cfg_par_d   = i_parity;
                    cfg_stop2_d = i_stop2;
                end
            end
            START: begin
                if (decision) begin
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        n_d        = '0;
                        stop_n_d   = 1'b0;
                        par_acc_d  = 1'b0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
                        brk_acc_d  = 1'b1;
                    end
                end
            end
            DATA: begin
                if (decision) begin
                    shift_d   = {vote, shift_q[DBIT-1:1]};
                    par_acc_d = par_acc_q ^ vote;
                    brk_acc_d = brk_acc_q & ~vote;
                    n_d       = n_q + NW'(1);
                    if (last_data) state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (decision) begin
                    perr_acc_d = ((par_acc_q ^ vote) != par_odd);
                    brk_acc_d  = brk_acc_q & ~vote;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (decision) begin
                    if (stop_n_q == cfg_stop2_q) begin
                        done_d     = 1'b1;
                        data_d     = shift_q >> sh_amt;
                        perr_d     = perr_acc_q;
                        ferr_d     = ferr_now;
                        brk_d      = brk_now;
                        brk_hold_d = brk_now;
                        state_d    = IDLE;
                    end else begin
                        stop_n_d   = 1'b1;
                        ferr_acc_d = ferr_now;
                        brk_acc_d  = brk_now;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            samp_q      <= '0;
            shift_q     <= '0;
            cfg_dbits_q <= '0;
            cfg_par_q   <= '0;
            cfg_stop2_q <= 1'b0;
            stop_n_q    <= 1'b0;
            par_acc_q   <= 1'b0;
            perr_acc_q  <= 1'b0;
            ferr_acc_q  <= 1'b0;
            brk_acc_q   <= 1'b0;
            brk_hold_q  <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            cfg_dbits_q <= cfg_dbits_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
            stop_n_q    <= stop_n_d;
            par_acc_q   <= par_acc_d;
            perr_acc_q  <= perr_acc_d;
            ferr_acc_q  <= ferr_acc_d;
            brk_acc_q   <= brk_acc_d;
            brk_hold_q  <= brk_hold_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            brk_q       <= brk_d;
            done_q      <= done_d;
        end
    end

    assign o_data         = data_q;
    assign o_rx_done_tick = done_q;
    assign o_parity_err   = perr_q;
    assign o_frame_err    = ferr_q;
    assign o_break        = brk_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomised frames for uart_rx_cfg, checked against a
// frame-level reference model of the expected character and flags.
module tb_uart_rx_cfg;

    localparam int DBIT = 8;
    localparam int OS   = 16;
    localparam int TD   = 4;
    localparam int BITC = OS * TD;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx  = 1'b1;
    logic [1:0]      dbits = 2'd0;
    logic [1:0]      par   = 2'd0;
    logic            stop2 = 1'b0;
    logic            s_tick;
    logic [DBIT-1:0] o_data;
    logic            done, perr, ferr, brk, busy;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;
    logic [10:0] doneq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign s_tick = ((cyc % TD) == TD - 1);

    always @(negedge clk) if (done === 1'b1) doneq.push_back({brk, ferr, perr, o_data});

    uart_rx_cfg #(.DBIT(DBIT), .OS(OS)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx           (rx),
        .i_s_tick       (s_tick),
        .i_dbits        (dbits),
        .i_parity       (par),
        .i_stop2        (stop2),
        .o_data         (o_data),
        .o_rx_done_tick (done),
        .o_parity_err   (perr),
        .o_frame_err    (ferr),
        .o_break        (brk),
        .o_busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] mask_data(input logic [7:0] d, input int nb);
        return 8'(int'(d) & ((1 << nb) - 1));
    endfunction

    function automatic logic par_bit(input logic [7:0] m, input logic [1:0] pm);
        return (pm == 2'b10) ? ~(^m) : (^m);
    endfunction

    task automatic wait_align();
        while ((cyc % TD) != TD - 1) @(negedge clk);
    endtask

    // Drives one frame; flip_j inverts only the mid-sample of that frame bit,
    // rst_j pulses reset in the middle of that frame bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pm,
                              input bit st2, input bit pflip, input bit s1, input bit s2,
                              input int flip_j, input int rst_j);
        bit bits[$];
        logic [7:0] m;
        m = mask_data(d, nb);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(m[i]);
        if (pm == 2'b01 || pm == 2'b10) bits.push_back(par_bit(m, pm) ^ pflip);
        bits.push_back(s1);
        if (st2) bits.push_back(s2);
        dbits = 2'(nb - 5);
        par   = pm;
        stop2 = st2;
        wait_align();
        for (int j = 0; j < bits.size(); j++) begin
            for (int c = 0; c < BITC; c++) begin
                rx = (j == flip_j && c >= 31 && c <= 34) ? ~bits[j] : bits[j];
                if (j == 1 && c == 0) begin
                    dbits = 2'($urandom);
                    par   = 2'($urandom);
                    stop2 = 1'($urandom);
                end
                if (j == rst_j && c == 32) begin
                    rst = 1'b1;
                    rx  = 1'b1;
                    repeat (3) @(negedge clk);
                    rst = 1'b0;
                    return;
                end
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] ed, input bit ep,
                                input bit ef, input bit eb);
        logic [10:0] r;
        check({tag, "_done"}, 32'(doneq.size() > 0), 32'd1);
        if (doneq.size() > 0) begin
            r = doneq.pop_front();
            check({tag, "_data"}, 32'(r[7:0]), 32'(ed));
            check({tag, "_perr"}, 32'(r[8]), 32'(ep));
            check({tag, "_ferr"}, 32'(r[9]), 32'(ef));
            check({tag, "_brk"},  32'(r[10]), 32'(eb));
        end
    endtask

    task automatic send_and_check(input string tag, input logic [7:0] d, input int nb,
                                  input logic [1:0] pm, input bit st2, input bit pflip,
                                  input bit s1, input bit s2, input int flip_j);
        logic [7:0] m;
        bit pen, pb;
        send_frame(d, nb, pm, st2, pflip, s1, s2, flip_j, -1);
        repeat (2 * BITC) @(negedge clk);
        m   = mask_data(d, nb);
        pen = (pm == 2'b01 || pm == 2'b10);
        pb  = par_bit(m, pm) ^ pflip;
        expect_frame(tag, m, pen && pflip, !s1 || (st2 && !s2),
                     (m == 8'h00) && (!pen || !pb) && !s1);
        check({tag, "_extra"}, 32'(doneq.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        int nb, fj;
        logic [1:0] pm;
        bit st2, pf, s1, s2;

        repeat (2) @(negedge clk);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", 32'({done, perr, ferr, brk}), 32'd0);

        // 8N1 back-to-back
        send_frame(8'h55, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        send_frame(8'hA3, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        repeat (2 * BITC) @(negedge clk);
        expect_frame("b2b_a", 8'h55, 1'b0, 1'b0, 1'b0);
        expect_frame("b2b_b", 8'hA3, 1'b0, 1'b0, 1'b0);

        send_and_check("7e1_ok",  8'h3A, 7, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        send_and_check("7e1_bad", 8'h3A, 7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, -1);
        send_and_check("5o2_stop", 8'h13, 5, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, -1);

        // Break: line low for 12 bit times, then high
        dbits = 2'd3; par = 2'b00; stop2 = 1'b0;
        wait_align();
        rx = 1'b0;
        repeat (11 * BITC) @(negedge clk);
        check("brk_hold_busy", 32'(busy), 32'd0);
        check("brk_count", 32'(doneq.size()), 32'd1);
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BITC) @(negedge clk);
        expect_frame("brk", 8'h00, 1'b0, 1'b1, 1'b1);
        check("brk_extra", 32'(doneq.size()), 32'd0);
        send_and_check("after_brk", 8'h81, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        // Idle glitch of 4 ticks
        wait_align();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        check("glitch_busy", 32'(busy), 32'd1);
        repeat (TD * 4 - 8) @(negedge clk);
        rx = 1'b1;
        repeat (BITC - TD * 4 + 8) @(negedge clk);
        check("glitch_idle", 32'(busy), 32'd0);
        check("glitch_nodone", 32'(doneq.size()), 32'd0);

        send_and_check("vote", 8'hF0, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3);

        // Reset during the 4th data bit
        send_frame(8'h5A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 4);
        repeat (2) @(negedge clk);
        check("mrst_data", 32'(o_data), 32'd0);
        check("mrst_flags", 32'({perr, ferr, brk, busy}), 32'd0);
        repeat (2 * BITC) @(negedge clk);
        check("mrst_nodone", 32'(doneq.size()), 32'd0);
        send_and_check("after_rst", 8'h7E, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);

        for (int k = 0; k < 16; k++) begin
            rd  = 8'($urandom);
            nb  = 5 + int'($urandom_range(3));
            pm  = 2'($urandom_range(3));
            st2 = 1'($urandom_range(1));
            pf  = ($urandom_range(3) == 0);
            s1  = ($urandom_range(7) != 0);
            s2  = ($urandom_range(7) != 0);
            fj  = ($urandom_range(1) == 1) ? 1 + int'($urandom_range(nb - 1)) : -1;
            send_and_check($sformatf("rnd%0d", k), rd, nb, pm, st2, pf, s1, s2, fj);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
